// File: rtl/field_pkg.sv
// Shared widths, FSM state type and the double-dabble step used by the
// field/score display buffer.
package field_pkg;
    localparam int FIELD_W    = 400;
    localparam int SCORE_W    = 32;
    localparam int BCD_DIGITS = 10;
    localparam int BCD_CYCLES = 32;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic {IDLE, PENDING} state_t;

    // One shift-add-3 step: correct every digit >= 5, then shift in the next binary bit.
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd, input logic b);
        logic [BCD_W-1:0] t;
        t = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
        end
        return {t[BCD_W-2:0], b};
    endfunction
endpackage

// File: rtl/field_frame_buffer_if.sv
// Update handshake between game logic (master) and the frame buffer (slave).
interface field_frame_buffer_if;
    logic [field_pkg::FIELD_W-1:0] iField;
    logic [field_pkg::SCORE_W-1:0] iScore;
    logic                          iUpd_valid;
    logic                          oUpd_ready;

    modport master (output iField, iScore, iUpd_valid, input  oUpd_ready);
    modport slave  (input  iField, iScore, iUpd_valid, output oUpd_ready);
endinterface

// File: rtl/score_bcd.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// The first step runs in the start cycle, so done rises 32 cycles after start.
// Only built when SCORE_BCD_EN is defined.
`ifdef SCORE_BCD_EN
module score_bcd
    import field_pkg::*;
(
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic [BCD_W-1:0]   bcd,
    output logic               done
);
    logic [SCORE_W-1:0] sh;
    logic [BCD_W-1:0]   acc;
    logic [5:0]         cnt;

    // Load and take the first step on start, then one step per cycle until cnt empties.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sh  <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (start) begin
            acc <= dd_step('0, bin[SCORE_W-1]);
            sh  <= {bin[SCORE_W-2:0], 1'b0};
            cnt <= 6'(BCD_CYCLES - 1);
        end else if (cnt != 6'd0) begin
            acc <= dd_step(acc, sh[SCORE_W-1]);
            sh  <= {sh[SCORE_W-2:0], 1'b0};
            cnt <= cnt - 6'd1;
        end
    end

    assign bcd  = acc;
    assign done = (cnt == 6'd0);
endmodule
`endif

// File: rtl/field_frame_buffer.sv
// Double-buffers field/score updates from game logic and releases them to the
// renderer only at a vertical-sync falling edge, so a frame never tears.
// Optional BCD score output: define SCORE_BCD_EN to build the converter;
// otherwise oScore_bcd stays 0 and commits need not wait for conversion.
module field_frame_buffer
    import field_pkg::*;
(
    input  logic                  iVGA_CLK,
    input  logic                  iRST_n,
    field_frame_buffer_if.slave   upd,
    input  logic                  iVS,
    output logic [FIELD_W-1:0]    oField,
    output logic [SCORE_W-1:0]    oScore,
    output logic [BCD_W-1:0]      oScore_bcd,
    output logic                  oCommit
);
    state_t             state_q, state_d;
    logic               vs_d, frame_start, capture, conv_done;
    logic [FIELD_W-1:0] shadow_field;
    logic [SCORE_W-1:0] shadow_score;
    logic [BCD_W-1:0]   bcd_res;

    assign upd.oUpd_ready = (state_q == IDLE);
    assign capture        = upd.iUpd_valid & upd.oUpd_ready;
    assign frame_start    = vs_d & ~iVS;

`ifdef SCORE_BCD_EN
    score_bcd u_bcd (
        .iVGA_CLK (iVGA_CLK),
        .iRST_n   (iRST_n),
        .start    (capture),
        .bin      (upd.iScore),
        .bcd      (bcd_res),
        .done     (conv_done)
    );
`else
    assign bcd_res   = '0;
    assign conv_done = 1'b1;
`endif

    // State register.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and commit strobe: commit only at a frame start once BCD is ready.
    always_comb begin
        state_d = state_q;
        oCommit = 1'b0;
        case (state_q)
            IDLE:    if (capture) state_d = PENDING;
            PENDING: if (frame_start && conv_done) begin
                         oCommit = 1'b1;
                         state_d = IDLE;
                     end
            default: state_d = IDLE;
        endcase
    end

    // Delayed vsync for falling-edge detection; idles high.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) vs_d <= 1'b1;
        else         vs_d <= iVS;
    end

    // Shadow copy of the accepted update.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            shadow_field <= '0;
            shadow_score <= '0;
        end else if (capture) begin
            shadow_field <= upd.iField;
            shadow_score <= upd.iScore;
        end
    end

    // Display registers move only on a commit.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oField     <= '0;
            oScore     <= '0;
            oScore_bcd <= '0;
        end else if (oCommit) begin
            oField     <= shadow_field;
            oScore     <= shadow_score;
            oScore_bcd <= bcd_res;
        end
    end
endmodule

// File: tb/tb_field_frame_buffer.sv
// Self-checking bench for field_frame_buffer: directed scenarios plus a
// randomized run, compared every cycle against a transaction-level model.
// Adapts to SCORE_BCD_EN being defined or not.
module tb_field_frame_buffer;
    import field_pkg::*;

`ifdef SCORE_BCD_EN
    localparam bit BCD_EN = 1'b1;
`else
    localparam bit BCD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b1;
    always #5 clk = ~clk;

    field_frame_buffer_if u_if ();
    logic [FIELD_W-1:0] oField;
    logic [SCORE_W-1:0] oScore;
    logic [BCD_W-1:0]   oScore_bcd;
    logic               oCommit;

    field_frame_buffer dut (
        .iVGA_CLK   (clk),
        .iRST_n     (rst_n),
        .upd        (u_if.slave),
        .iVS        (vs),
        .oField     (oField),
        .oScore     (oScore),
        .oScore_bcd (oScore_bcd),
        .oCommit    (oCommit)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // ---------------- reference model ----------------
    // One pending update at most; it is shown at the first vsync fall that is
    // at least BCD_CYCLES edges after acceptance (any later edge without BCD).
    logic               m_pend;
    logic               m_vs;
    logic [FIELD_W-1:0] m_sf, m_df;
    logic [SCORE_W-1:0] m_ss, m_ds;
    int                 m_cyc, m_cap;

    function automatic bit m_done();
        return !BCD_EN || ((m_cyc - m_cap) >= BCD_CYCLES);
    endfunction

    function automatic logic [BCD_W-1:0] to_bcd(input logic [SCORE_W-1:0] v);
        logic [BCD_W-1:0] r;
        longint x;
        r = '0;
        x = longint'(v);
        for (int i = 0; i < BCD_DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0; m_vs <= 1'b1;
            m_sf <= '0; m_df <= '0; m_ss <= '0; m_ds <= '0;
            m_cyc <= 0; m_cap <= 0;
        end else begin
            if (m_pend && m_vs && !vs && m_done()) begin
                m_df <= m_sf; m_ds <= m_ss; m_pend <= 1'b0;
            end else if (!m_pend && u_if.iUpd_valid) begin
                m_sf <= u_if.iField; m_ss <= u_if.iScore; m_pend <= 1'b1; m_cap <= m_cyc;
            end
            m_vs  <= vs;
            m_cyc <= m_cyc + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    task automatic check_cycle();
        logic             ec;
        logic [BCD_W-1:0] eb;
        bit               bad;
        ec  = m_pend && m_vs && !vs && m_done();
        eb  = BCD_EN ? to_bcd(m_ds) : '0;
        bad = 0;
        n_tests++;
        if (oCommit !== ec) begin
            $display("FAIL cyc_commit got %0b exp %0b t=%0t", oCommit, ec, $time); bad = 1;
        end
        if (u_if.oUpd_ready !== !m_pend) begin
            $display("FAIL cyc_ready got %0b exp %0b t=%0t", u_if.oUpd_ready, !m_pend, $time); bad = 1;
        end
        if (oScore !== m_ds) begin
            $display("FAIL cyc_score got %0h exp %0h t=%0t", oScore, m_ds, $time); bad = 1;
        end
        if (oScore_bcd !== eb) begin
            $display("FAIL cyc_bcd got %0h exp %0h t=%0t", oScore_bcd, eb, $time); bad = 1;
        end
        if (oField !== m_df) begin
            $display("FAIL cyc_field got %h exp %h t=%0t", oField, m_df, $time); bad = 1;
        end
        if (bad) n_fail++;
    endtask

    always @(negedge clk) if (chk_en) check_cycle();

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rand_field(output logic [FIELD_W-1:0] f);
        f = '0;
        for (int i = 0; i < 13; i++) f = {f[FIELD_W-33:0], 32'($urandom)};
    endtask

    // Drop iVS now (sampled at the next edge), check the strobe, then raise it again.
    task automatic fall_chk(input string nm, input logic exp);
        vs = 1'b0;
        @(negedge clk);
        chk(nm, 64'(oCommit), 64'(exp));
        tick(4);
        vs = 1'b1;
        tick(2);
    endtask

    task automatic offer(input logic [FIELD_W-1:0] f, input logic [SCORE_W-1:0] s);
        u_if.iField = f; u_if.iScore = s; u_if.iUpd_valid = 1'b1;
        tick(1);
        u_if.iUpd_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [FIELD_W-1:0] f0, fr;
    int vs_cnt, vs_low, rst_hold;

    initial begin
        u_if.iField = '0; u_if.iScore = '0; u_if.iUpd_valid = 1'b0;
        tick(3);
        chk("rst_score", 64'(oScore), 64'd0);
        chk("rst_ready", 64'(u_if.oUpd_ready), 64'd1);
        chk("rst_commit", 64'(oCommit), 64'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // quiet frame after reset
        tick(100);
        chk("idle_score", 64'(oScore), 64'd0);
        chk("idle_bcd", 64'(oScore_bcd), 64'd0);
        chk("idle_field0", 64'(oField == '0), 64'd1);
        chk("idle_ready", 64'(u_if.oUpd_ready), 64'd1);

        // basic update, vsync 50 cycles after capture
        f0 = '0; f0[0] = 1'b1;
        offer(f0, 32'd1234);
        tick(49);
        fall_chk("c1234_commit", 1'b1);
        chk("c1234_score", 64'(oScore), 64'd1234);
        chk("c1234_bcd", 64'(oScore_bcd), BCD_EN ? 64'h0000001234 : 64'd0);
        chk("c1234_field0", 64'(oField[0]), 64'd1);
        chk("model_score", 64'(m_ds), 64'd1234);

        // max score; early vsync must wait when conversion is in use
        offer('0, 32'hFFFF_FFFF);
        tick(9);
        fall_chk("cmax_first", !BCD_EN);
        tick(993);
        fall_chk("cmax_second", BCD_EN);
        chk("cmax_score", 64'(oScore), 64'hFFFF_FFFF);
        chk("cmax_bcd", 64'(oScore_bcd), BCD_EN ? 64'h4294967295 : 64'd0);
        chk("model_bcd", 64'(to_bcd(m_ds)), 64'h4294967295);

        // valid held high with changing data: only the first value sticks
        rand_field(f0);
        u_if.iField = f0; u_if.iScore = 32'd555; u_if.iUpd_valid = 1'b1;
        tick(1);
        for (int i = 0; i < 40; i++) begin
            rand_field(fr);
            u_if.iField = fr; u_if.iScore = $urandom;
            tick(1);
        end
        chk("hold_ready_pend", 64'(u_if.oUpd_ready), 64'd0);
        vs = 1'b0; u_if.iUpd_valid = 1'b0;
        @(negedge clk);
        chk("hold_commit", 64'(oCommit), 64'd1);
        chk("hold_ready_commit", 64'(u_if.oUpd_ready), 64'd0);
        tick(1);
        chk("hold_ready_after", 64'(u_if.oUpd_ready), 64'd1);
        chk("hold_score", 64'(oScore), 64'd555);
        chk("hold_field", 64'(oField == f0), 64'd1);
        tick(3); vs = 1'b1; tick(2);

        // capture coincides with a frame start
        u_if.iScore = 32'd4321; u_if.iField = '0; u_if.iUpd_valid = 1'b1; vs = 1'b0;
        @(negedge clk);
        chk("coin_nocommit", 64'(oCommit), 64'd0);
        tick(1);
        u_if.iUpd_valid = 1'b0;
        tick(2); vs = 1'b1; tick(36);
        fall_chk("coin_commit", 1'b1);
        chk("coin_score", 64'(oScore), 64'd4321);

        // reset while pending discards the update
        offer('1, 32'd777);
        tick(5);
        rst_n = 1'b0;
        tick(2);
        chk("rstp_score", 64'(oScore), 64'd0);
        chk("rstp_field", 64'(oField == '0), 64'd1);
        chk("rstp_ready", 64'(u_if.oUpd_ready), 64'd1);
        chk("rstp_commit", 64'(oCommit), 64'd0);
        rst_n = 1'b1;
        tick(40);
        fall_chk("rstp_nocommit", 1'b0);
        chk("rstp_score_after", 64'(oScore), 64'd0);

        // randomized traffic, random frame lengths and occasional resets
        vs_cnt = 15; vs_low = 0; rst_hold = 0;
        for (int c = 0; c < 5000; c++) begin
            if (vs_low > 0) begin
                vs_low--;
                if (vs_low == 0) vs = 1'b1;
            end else if (vs_cnt == 0) begin
                vs = 1'b0; vs_low = 3; vs_cnt = $urandom_range(80, 10);
            end else vs_cnt--;
            u_if.iUpd_valid = ($urandom % 3 == 0);
            case ($urandom % 8)
                0:       u_if.iScore = '0;
                1:       u_if.iScore = 32'hFFFF_FFFF;
                default: u_if.iScore = $urandom;
            endcase
            rand_field(fr);
            u_if.iField = fr;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if ($urandom % 700 == 0) begin
                rst_n = 1'b0; rst_hold = 2;
            end
            tick(1);
        end
        rst_n = 1'b1;
        u_if.iUpd_valid = 1'b0;
        tick(2);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/field_frame_buffer.md
FIELD_FRAME_BUFFER -- requirements
Module: field_frame_buffer

Interface
REQ-001 iVGA_CLK  input  1  pixel clock; sole clock of the block.
REQ-002 iRST_n  input  1  asynchronous, active-low reset.
REQ-003 iField  input  400  field image from game logic; opaque bit vector.
REQ-004 iScore  input  32  unsigned binary score from game logic.
REQ-005 iUpd_valid  input  1  game logic offers iField/iScore for display.
REQ-006 oUpd_ready  output  1  block can accept an update; high only in IDLE.
REQ-007 iVS  input  1  active-low vertical sync from the sync generator, same clock domain.
REQ-008 oField  output  400  frame-stable field for the display renderer.
REQ-009 oScore  output  32  frame-stable binary score.
REQ-010 oScore_bcd  output  40  frame-stable score as 10 BCD digits, digit 0 in [3:0].
REQ-011 oCommit  output  1  one-cycle pulse on each display-register update.

Function
REQ-012 Handshake: capture iField/iScore into shadow registers on any rising iVGA_CLK edge with iUpd_valid=1 and oUpd_ready=1.
REQ-013 FSM states: IDLE, PENDING; reset enters IDLE.
REQ-014 IDLE -> PENDING on capture; oUpd_ready is decoded from state (IDLE=1, PENDING=0).
REQ-015 Frame-start detection: vs_d register samples iVS; frame start = vs_d=1 and iVS=0 (falling edge).
REQ-016 PENDING -> IDLE on the first frame start with BCD conversion done: copy shadow to oField/oScore/oScore_bcd, pulse oCommit in that same cycle.
REQ-017 Frame start before conversion done: no commit; wait for the next frame start (no mid-frame updates).
REQ-018 Frame start in the capture cycle: ignored (state still IDLE); commit occurs at a later frame start.
REQ-019 BCD conversion: shift-add-3 (double dabble), one bit per cycle, starts in the capture cycle, done exactly 32 cycles later.
REQ-020 BCD range: 0 to 4294967295 exactly; no saturation, no overflow.
REQ-021 Display outputs change only in the oCommit cycle; otherwise hold.
REQ-022 iUpd_valid while PENDING: not accepted; game logic holds data until oUpd_ready=1.

Reset
REQ-023 Asserted iRST_n: state IDLE; oField, oScore, oScore_bcd, oCommit = 0; shadow and BCD registers = 0; vs_d = 1.
REQ-024 oUpd_ready follows IDLE during reset (reads 1); no capture while iRST_n=0.
REQ-025 Reset during PENDING: the pending update is discarded; display outputs return to 0.

Configuration
REQ-026 Macro SCORE_BCD_EN defined: score_bcd instantiated; REQ-016/017/019 apply.
REQ-027 Macro SCORE_BCD_EN undefined: no converter; oScore_bcd tied to 0; conversion treated as done in every cycle, so PENDING commits at the first frame start after capture.

Structure
REQ-028 Shared package field_pkg holds FIELD_W=400, SCORE_W=32, BCD_DIGITS=10, BCD_CYCLES=32, and the FSM state type.
REQ-029 Converter is one sub-module, score_bcd: start, 32-bit binary in, 40-bit BCD out, done flag.
REQ-030 No other sub-modules.

Verification
REQ-031 Reset release, iVS held high for 100 cycles -> all outputs 0, oUpd_ready=1, no oCommit.
REQ-032 Capture iScore=1234, iField bit0=1; iVS falls 50 cycles later -> oCommit one cycle at that edge; oScore=1234, oScore_bcd=40'h0000001234, oField[0]=1.
REQ-033 Capture iScore=4294967295; iVS falls 10 cycles later, then again 1000 cycles later -> no commit at first edge; commit at second edge with oScore_bcd=40'h4294967295.
REQ-034 iUpd_valid held high with changing data during PENDING -> only the first value is captured; oUpd_ready=0 until the cycle after oCommit.
REQ-035 Capture cycle coincides with iVS falling edge -> no commit then; commit at next falling edge (>=32 cycles later).
REQ-036 Assert iRST_n=0 mid-PENDING -> outputs 0; after release, state IDLE and no oCommit at the next frame start.
